multi_axis_rate_pid: RTL and testbench
======================================

# multi_axis_rate_pid

Parametrised successor to the three-instance body-rate controller: one time-multiplexed PID datapath serves NUM_AXES rate channels in sequence. Targets, IMU rates and runtime gains are captured on a start edge; integrator state is kept per channel. All outputs publish together, then a completion pulse goes to the motor mixer. The block sits between the angle controller and the motor mixer.

## Interface
- NUM_AXES, 3: channel count; channel i occupies bits [i*W +: W] of every flat bus (0=yaw, 1=roll, 2=pitch).
- IN_WIDTH, 16: signed width of target and actual rates.
- OUT_WIDTH, 16: signed width of rate outputs.
- GAIN_WIDTH, 16: unsigned gain width.
- GAIN_SHIFT, 4: arithmetic right shift applied to the summed products.
- INV_MASK, 3'b010: bit i set negates channel i's actual rate (roll IMU is flipped).
- INTEG_LIMIT, 4096: symmetric integrator clamp, ±INTEG_LIMIT.
- us_clk  in  1  1 MHz system clock.
- resetn  in  1  asynchronous, active-low reset.
- start_signal  in  1  a rising edge (sampled on us_clk) starts a cycle.
- clear_integrators  in  1  sampled at the latching edge; zeroes integrators and prev_err for that cycle.
- target_flat  in  NUM_AXES*IN_WIDTH  signed target rates.
- actual_flat  in  NUM_AXES*IN_WIDTH  signed IMU rates.
- kp_flat, ki_flat, kd_flat  in  NUM_AXES*GAIN_WIDTH  per-channel gains.
- rate_out_flat  out  NUM_AXES*OUT_WIDTH  saturated signed rate commands.
- busy  out  1  high from the latching edge until DONE exits.
- complete_signal  out  1  one-cycle pulse when outputs are updated.
- overrun  out  1  one-cycle pulse when a start edge arrives while busy.

## Operation
- Edge detect: start_d registers start_signal. The edge condition is start_signal & !start_d.
- States: IDLE, ERR, MUL_P, MUL_I, MUL_D, SUM, DONE. Channel index ch counts 0..NUM_AXES-1.
- IDLE + edge: latch all flat inputs, set busy, ch=0, go to ERR. If clear_integrators=1, zero every integ and prev_err register at this edge.
- ERR:
  - a = actual, negated if INV_MASK[ch]. Compute in IN_WIDTH+1 bits so negating the minimum value cannot overflow.
  - err = target - a, width IN_WIDTH+2.
  - integ_c = clamp(integ[ch] + err, ±INTEG_LIMIT).
  - der = err - prev_err[ch].
- MUL_P / MUL_I / MUL_D: a single signed multiplier computes err*kp, integ_c*ki and der*kd in turn. Each product is added into a wide accumulator; the accumulator is cleared in ERR. Gains are zero-extended.
- SUM:
  - shifted = acc >>> GAIN_SHIFT.
  - Saturate shifted to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and store it in shadow[ch].
  - Update integ[ch] <= integ_c and prev_err[ch] <= err.
  - If ch is the last channel, go to DONE; otherwise increment ch and go to ERR.
- DONE: rate_out_flat <= all shadows simultaneously, complete_signal=1, busy=0 on exit, go to IDLE.
- A start edge in any non-IDLE state is ignored and pulses overrun for one cycle. The in-progress cycle is unaffected.
- A start edge in DONE also counts as overrun; the block is not re-armed until IDLE.
- A start_signal held high produces a single cycle only.

## Timing
- Reset values: rate_out_flat=0, complete_signal=0, busy=0, overrun=0, all integ/prev_err/shadow=0, state=IDLE, start_d=0.
- resetn low at any time aborts the cycle immediately. Outputs return to their reset values and no complete pulse is issued.
- Latency: with the latching edge as edge 0, each channel occupies 5 cycles. DONE is entered at edge 5·NUM_AXES (15 for NUM_AXES=3).
- rate_out_flat changes and complete_signal rises at edge 5·NUM_AXES. complete_signal falls one edge later.
- busy rises at edge 0 and falls at edge 5·NUM_AXES+1.
- Minimum start-to-start spacing: 5·NUM_AXES+2 cycles, counting the edge needed to re-arm start_d.
- rate_out_flat holds its value between cycles.

## Test plan
Defaults for all scenarios: NUM_AXES=3, GAIN_SHIFT=4, INV_MASK=3'b010.
- Reset: assert resetn low mid-cycle -> every output is 0 and no complete pulse. After release, the first cycle with zero gains -> outputs 0.
- P-only, kp=16, ki=kd=0:
  - ch0 target 100, actual 40 -> 60.
  - ch1 target 0, actual 50 (inverted) -> 50.
  - ch2 target -20, actual 0 -> -20.
  - complete_signal is high exactly at edge 15, for one cycle.
- I-only, ki=16, constant err 400, INTEG_LIMIT=1000:
  - Successive cycles -> 400, 800, 1000, 1000.
  - clear_integrators=1 on the next cycle -> 400.
- D-only, kd=16: err 10 then 30 on consecutive cycles -> 10, then 20.
- Saturation, kp=0x7FFF:
  - err +1000 -> 0x7FFF.
  - err -1000 -> 0x8000.
  - target 0x8000 with actual 0x7FFF on a non-inverted channel -> 0x8000 (no wrap).
- Overrun: a second start edge at edge 7 -> one-cycle overrun pulse, no restart, complete still at edge 15. A held-high start yields exactly one cycle.

Source files
------------

// File: rtl/multi_axis_rate_pid_if.sv
// Handshake and data bus between the angle controller, the rate PID and the motor mixer.
// Every flat bus carries channel i at bits [i*W +: W].
interface multi_axis_rate_pid_if #(
    parameter int NUM_AXES   = 3,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int GAIN_WIDTH = 16
);
    logic                             start_signal;
    logic                             clear_integrators;
    logic [NUM_AXES*IN_WIDTH-1:0]     target_flat;
    logic [NUM_AXES*IN_WIDTH-1:0]     actual_flat;
    logic [NUM_AXES*GAIN_WIDTH-1:0]   kp_flat;
    logic [NUM_AXES*GAIN_WIDTH-1:0]   ki_flat;
    logic [NUM_AXES*GAIN_WIDTH-1:0]   kd_flat;
    logic [NUM_AXES*OUT_WIDTH-1:0]    rate_out_flat;
    logic                             busy;
    logic                             complete_signal;
    logic                             overrun;

    modport master (
        output start_signal, clear_integrators, target_flat, actual_flat,
               kp_flat, ki_flat, kd_flat,
        input  rate_out_flat, busy, complete_signal, overrun
    );

    modport slave (
        input  start_signal, clear_integrators, target_flat, actual_flat,
               kp_flat, ki_flat, kd_flat,
        output rate_out_flat, busy, complete_signal, overrun
    );
endinterface

// File: rtl/multi_axis_rate_pid.sv
// Time-multiplexed body-rate PID: one multiplier walks NUM_AXES channels (5 cycles each),
// then all saturated outputs publish together with a one-cycle complete pulse.
module multi_axis_rate_pid #(
    parameter int                    NUM_AXES    = 3,
    parameter int                    IN_WIDTH    = 16,
    parameter int                    OUT_WIDTH   = 16,
    parameter int                    GAIN_WIDTH  = 16,
    parameter int                    GAIN_SHIFT  = 4,
    parameter logic [NUM_AXES-1:0]   INV_MASK    = 3'b010,
    parameter int                    INTEG_LIMIT = 4096
) (
    input  logic                  us_clk,
    input  logic                  resetn,
    multi_axis_rate_pid_if.slave  bus
);
    localparam int CH_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam int EW   = IN_WIDTH + 2;   // error / integrator width
    localparam int DW   = IN_WIDTH + 3;   // derivative and multiplier operand width
    localparam int MW   = GAIN_WIDTH + 1; // zero-extended gain as a signed operand
    localparam int PW   = DW + MW;
    localparam int AW   = PW + 2;         // headroom for three summed products
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_AXES - 1);
    localparam logic signed [EW:0]   LIM_P   = (EW+1)'(INTEG_LIMIT);
    localparam logic signed [EW:0]   LIM_N   = -LIM_P;
    localparam longint               OUT_MAX_L = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
    localparam logic signed [AW-1:0] OUT_MAX = AW'(OUT_MAX_L);
    localparam logic signed [AW-1:0] OUT_MIN = -OUT_MAX - AW'(1);

    typedef enum logic [2:0] {IDLE, ERR, MUL_P, MUL_I, MUL_D, SUM, DONE} state_t;

    state_t                         state_reg, state_next;
    logic                           start_d_reg;
    logic [CH_W-1:0]                ch_reg;
    logic [NUM_AXES*IN_WIDTH-1:0]   target_reg, actual_reg;
    logic [NUM_AXES*GAIN_WIDTH-1:0] kp_reg, ki_reg, kd_reg;
    logic signed [EW-1:0]           err_reg, integ_c_reg;
    logic signed [DW-1:0]           der_reg;
    logic signed [AW-1:0]           acc_reg;
    logic                           busy_reg, complete_reg, overrun_reg;

    logic signed [EW-1:0]           integ_arr [NUM_AXES];
    logic signed [EW-1:0]           prev_arr  [NUM_AXES];
    logic [OUT_WIDTH-1:0]           rate_arr  [NUM_AXES];

    logic                           start_edge;
    logic signed [IN_WIDTH:0]       act_ext, tgt_ext, a_val;
    logic signed [EW-1:0]           err_val, integ_c_val;
    logic signed [EW:0]             integ_sum;
    logic signed [DW-1:0]           der_val, mul_op;
    logic [GAIN_WIDTH-1:0]          mul_gain;
    logic signed [PW-1:0]           product;
    logic signed [AW-1:0]           shifted;
    logic [OUT_WIDTH-1:0]           sat_val;

    assign start_edge = bus.start_signal & ~start_d_reg;

    // Error, clamped integrator and derivative for the current channel
    always_comb begin
        tgt_ext   = (IN_WIDTH+1)'($signed(target_reg[int'(ch_reg)*IN_WIDTH +: IN_WIDTH]));
        act_ext   = (IN_WIDTH+1)'($signed(actual_reg[int'(ch_reg)*IN_WIDTH +: IN_WIDTH]));
        a_val     = INV_MASK[ch_reg] ? -act_ext : act_ext;
        err_val   = EW'(tgt_ext) - EW'(a_val);
        integ_sum = (EW+1)'(integ_arr[ch_reg]) + (EW+1)'(err_val);
        if (integ_sum > LIM_P)
            integ_c_val = EW'(LIM_P);
        else if (integ_sum < LIM_N)
            integ_c_val = EW'(LIM_N);
        else
            integ_c_val = EW'(integ_sum);
        der_val = DW'(err_val) - DW'(prev_arr[ch_reg]);
    end

    always_comb begin
        mul_op   = DW'(err_reg);
        mul_gain = kp_reg[int'(ch_reg)*GAIN_WIDTH +: GAIN_WIDTH];
        case (state_reg)
            MUL_I: begin
                mul_op   = DW'(integ_c_reg);
                mul_gain = ki_reg[int'(ch_reg)*GAIN_WIDTH +: GAIN_WIDTH];
            end
            MUL_D: begin
                mul_op   = der_reg;
                mul_gain = kd_reg[int'(ch_reg)*GAIN_WIDTH +: GAIN_WIDTH];
            end
            default: ;
        endcase
        product = mul_op * $signed({1'b0, mul_gain});
    end

    always_comb begin
        shifted = acc_reg >>> GAIN_SHIFT;
        if (shifted > OUT_MAX)
            sat_val = OUT_WIDTH'(OUT_MAX);
        else if (shifted < OUT_MIN)
            sat_val = OUT_WIDTH'(OUT_MIN);
        else
            sat_val = OUT_WIDTH'(shifted);
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_edge) state_next = ERR;
            ERR:     state_next = MUL_P;
            MUL_P:   state_next = MUL_I;
            MUL_I:   state_next = MUL_D;
            MUL_D:   state_next = SUM;
            SUM:     state_next = (ch_reg == LAST_CH) ? DONE : ERR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            start_d_reg  <= 1'b0;
            ch_reg       <= '0;
            target_reg   <= '0;
            actual_reg   <= '0;
            kp_reg       <= '0;
            ki_reg       <= '0;
            kd_reg       <= '0;
            err_reg      <= '0;
            integ_c_reg  <= '0;
            der_reg      <= '0;
            acc_reg      <= '0;
            busy_reg     <= 1'b0;
            complete_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            start_d_reg <= bus.start_signal;
            overrun_reg <= start_edge && (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    if (start_edge) begin
                        target_reg <= bus.target_flat;
                        actual_reg <= bus.actual_flat;
                        kp_reg     <= bus.kp_flat;
                        ki_reg     <= bus.ki_flat;
                        kd_reg     <= bus.kd_flat;
                        busy_reg   <= 1'b1;
                        ch_reg     <= '0;
                    end
                end
                ERR: begin
                    err_reg     <= err_val;
                    integ_c_reg <= integ_c_val;
                    der_reg     <= der_val;
                    acc_reg     <= '0;
                end
                MUL_P, MUL_I, MUL_D: acc_reg <= acc_reg + AW'(product);
                SUM: begin
                    if (ch_reg == LAST_CH)
                        complete_reg <= 1'b1;
                    else
                        ch_reg <= ch_reg + CH_W'(1);
                end
                DONE: begin
                    complete_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Per-channel state; the output register loads on the last SUM so all channels publish together
    generate
        for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_ch
            logic signed [EW-1:0]  integ_q, prev_q;
            logic [OUT_WIDTH-1:0]  shadow_q, rate_q;

            always_ff @(posedge us_clk or negedge resetn) begin
                if (!resetn) begin
                    integ_q  <= '0;
                    prev_q   <= '0;
                    shadow_q <= '0;
                    rate_q   <= '0;
                end else begin
                    if (state_reg == IDLE && start_edge && bus.clear_integrators) begin
                        integ_q <= '0;
                        prev_q  <= '0;
                    end else if (state_reg == SUM && ch_reg == CH_W'(gi)) begin
                        integ_q  <= integ_c_reg;
                        prev_q   <= err_reg;
                        shadow_q <= sat_val;
                    end
                    if (state_reg == SUM && ch_reg == LAST_CH)
                        rate_q <= (ch_reg == CH_W'(gi)) ? sat_val : shadow_q;
                end
            end

            assign integ_arr[gi] = integ_q;
            assign prev_arr[gi]  = prev_q;
            assign rate_arr[gi]  = rate_q;
        end
    endgenerate

    always_comb begin
        bus.rate_out_flat = '0;
        for (int i = 0; i < NUM_AXES; i++)
            bus.rate_out_flat[i*OUT_WIDTH +: OUT_WIDTH] = rate_arr[i];
    end

    assign bus.busy            = busy_reg;
    assign bus.complete_signal = complete_reg;
    assign bus.overrun         = overrun_reg;
endmodule

// File: tb/tb_multi_axis_rate_pid.sv
// Table-driven bench for multi_axis_rate_pid: expected outputs are queued at each start
// and popped by a monitor on complete_signal; timing corners are checked inline.
`timescale 1ns/1ps
module tb_multi_axis_rate_pid;
    localparam int N = 3;
    localparam int W = 16;

    logic clk;
    logic rst_n;

    multi_axis_rate_pid_if #(.NUM_AXES(N), .IN_WIDTH(W), .OUT_WIDTH(W), .GAIN_WIDTH(W)) bus ();

    multi_axis_rate_pid #(
        .NUM_AXES(N), .IN_WIDTH(W), .OUT_WIDTH(W), .GAIN_WIDTH(W),
        .GAIN_SHIFT(4), .INV_MASK(3'b010), .INTEG_LIMIT(1000)
    ) dut (
        .us_clk (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] target;
        logic [N*W-1:0] actual;
        logic [N*W-1:0] kp;
        logic [N*W-1:0] ki;
        logic [N*W-1:0] kd;
        logic           clr;
        logic [N*W-1:0] expect_out;
    } vec_t;

    vec_t           vecs [11];
    logic [N*W-1:0] exp_q [$];
    int             tests = 0;
    int             fails = 0;
    int             comp_count = 0;
    int             ovr_count = 0;

    function automatic logic [N*W-1:0] p3(input int c0, input int c1, input int c2);
        return {16'(c2), 16'(c1), 16'(c0)};
    endfunction

    function automatic vec_t mk(input int t0, input int t1, input int t2,
                                input int a0, input int a1, input int a2,
                                input int kp, input int ki, input int kd, input bit clr,
                                input int e0, input int e1, input int e2);
        vec_t v;
        v.target     = p3(t0, t1, t2);
        v.actual     = p3(a0, a1, a2);
        v.kp         = p3(kp, kp, kp);
        v.ki         = p3(ki, ki, ki);
        v.kd         = p3(kd, kd, kd);
        v.clr        = clr;
        v.expect_out = p3(e0, e1, e2);
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        logic [N*W-1:0] e;
        #1;
        if (bus.overrun === 1'b1) ovr_count++;
        if (bus.complete_signal === 1'b1) begin
            comp_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_complete: got complete pulse, expected none");
            end else begin
                e = exp_q.pop_front();
                for (int c = 0; c < N; c++)
                    check($sformatf("ch%0d_out", c),
                          longint'($signed(bus.rate_out_flat[c*W +: W])),
                          longint'($signed(e[c*W +: W])));
                $display("[TB] cycle done: out = %0d %0d %0d",
                         $signed(bus.rate_out_flat[0 +: W]), $signed(bus.rate_out_flat[W +: W]),
                         $signed(bus.rate_out_flat[2*W +: W]));
            end
        end
    end

    task automatic drive_vec(input vec_t v);
        bus.target_flat       = v.target;
        bus.actual_flat       = v.actual;
        bus.kp_flat           = v.kp;
        bus.ki_flat           = v.ki;
        bus.kd_flat           = v.kd;
        bus.clear_integrators = v.clr;
    endtask

    task automatic run_cycle(input vec_t v, input int ovr_edge, input bit hold);
        int c0;
        int o0;
        @(negedge clk);
        drive_vec(v);
        bus.start_signal = 1'b1;
        exp_q.push_back(v.expect_out);
        c0 = comp_count;
        o0 = ovr_count;
        for (int e = 0; e <= 16; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) begin
                check("busy_rise", longint'(bus.busy), 1);
                if (!hold) bus.start_signal = 1'b0;
                bus.clear_integrators = 1'b0;
            end
            if (ovr_edge > 0 && e == ovr_edge - 1) bus.start_signal = 1'b1;
            if (ovr_edge > 0 && e == ovr_edge) begin
                check("overrun_pulse", longint'(bus.overrun), 1);
                bus.start_signal = 1'b0;
            end
            if (ovr_edge > 0 && e == ovr_edge + 1) check("overrun_fall", longint'(bus.overrun), 0);
            if (e == 14) check("complete_early", longint'(bus.complete_signal), 0);
            if (e == 15) begin
                check("complete_edge15", longint'(bus.complete_signal), 1);
                check("busy_at_done", longint'(bus.busy), 1);
            end
            if (e == 16) begin
                check("complete_fall", longint'(bus.complete_signal), 0);
                check("busy_fall", longint'(bus.busy), 0);
            end
        end
        if (hold) begin
            repeat (20) @(posedge clk);
            @(negedge clk);
            bus.start_signal = 1'b0;
            repeat (2) @(posedge clk);
        end
        #2;
        check("complete_count", longint'(comp_count - c0), 1);
        check("overrun_count", longint'(ovr_count - o0), (ovr_edge > 0) ? 1 : 0);
        check("sb_empty", longint'(exp_q.size()), 0);
    endtask

    initial begin
        int c0;
        vecs[0]  = mk(100, 0, -20,   40, 50, 0,       0,  0,  0, 1'b0,      0,      0,      0);
        vecs[1]  = mk(100, 0, -20,   40, 50, 0,      16,  0,  0, 1'b0,     60,     50,    -20);
        vecs[2]  = mk(32767, 0, 5,   -32768, -32768, 5, 16, 0, 0, 1'b0,  32767, -32768,      0);
        vecs[3]  = mk(400, 400, 400,  0, 0, 0,        0, 16,  0, 1'b1,    400,    400,    400);
        vecs[4]  = mk(400, 400, 400,  0, 0, 0,        0, 16,  0, 1'b0,    800,    800,    800);
        vecs[5]  = mk(400, 400, 400,  0, 0, 0,        0, 16,  0, 1'b0,   1000,   1000,   1000);
        vecs[6]  = mk(400, 400, 400,  0, 0, 0,        0, 16,  0, 1'b0,   1000,   1000,   1000);
        vecs[7]  = mk(400, 400, 400,  0, 0, 0,        0, 16,  0, 1'b1,    400,    400,    400);
        vecs[8]  = mk(10, 10, 0,      0, 0, -10,      0,  0, 16, 1'b1,     10,     10,     10);
        vecs[9]  = mk(30, 30, 0,      0, 0, -30,      0,  0, 16, 1'b0,     20,     20,     20);
        vecs[10] = mk(1000, -1000, -32768, 0, 0, 32767, 32767, 0, 0, 1'b0, 32767, -32768, -32768);

        rst_n            = 1'b0;
        bus.start_signal = 1'b0;
        drive_vec(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        check("rst_rate_out", longint'(bus.rate_out_flat), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_complete", longint'(bus.complete_signal), 0);
        check("rst_overrun", longint'(bus.overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_cycle(vecs[1], 0, 1'b0);

        // Abort a cycle mid-flight with an asynchronous reset
        @(negedge clk);
        drive_vec(vecs[1]);
        bus.start_signal = 1'b1;
        c0 = comp_count;
        @(posedge clk);
        #1;
        bus.start_signal = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rate_out", longint'(bus.rate_out_flat), 0);
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_complete", longint'(bus.complete_signal), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("abort_no_complete", longint'(comp_count - c0), 0);

        run_cycle(vecs[0], 0, 1'b0);
        for (int i = 2; i <= 10; i++)
            run_cycle(vecs[i], 0, 1'b0);

        run_cycle(vecs[1], 7, 1'b0);
        run_cycle(vecs[1], 0, 1'b1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
